// File: rtl/muldiv_unit_if.sv
// Handshake/data bundle between the pipeline and the multiply/divide unit.
// The pipeline side drives operands and commands; the unit returns HI/LO and status.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] foutput1;
  logic [31:0] foutput2;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, foutput1, foutput2, mthi, mtlo, flush,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, foutput1, foutput2, mthi, mtlo, flush,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit: 32-step shift-add multiply and
// restoring divide on magnitudes, followed by a sign-fix/commit state.
module muldiv_unit #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic        r_done;
  logic [31:0] r_hi, r_lo;
  logic [1:0]  r_op;
  logic        r_sa, r_sb;
  logic [31:0] r_m;
  logic [63:0] r_acc;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  logic        w_launch, w_signed, w_sa, w_sb;
  logic [31:0] w_amag, w_bmag;
  assign w_launch = (r_state == S_IDLE) & bus.start & ~bus.flush;
  assign w_signed = ~bus.op[0];
  assign w_sa     = w_signed & bus.foutput1[31];
  assign w_sb     = w_signed & bus.foutput2[31];
  assign w_amag   = w_sa ? neg32(bus.foutput1) : bus.foutput1;
  assign w_bmag   = w_sb ? neg32(bus.foutput2) : bus.foutput2;

  // One iteration of each algorithm; r_m holds the multiplicand or the divisor.
  logic [32:0] w_msum, w_shift, w_diff;
  logic [63:0] w_mstep, w_dstep;
  assign w_msum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
  assign w_mstep = {w_msum, r_acc[31:1]};
  assign w_shift = {r_acc[63:32], r_acc[31]};
  assign w_diff  = w_shift - {1'b0, r_m};
  assign w_dstep = w_diff[32] ? {w_shift[31:0], r_acc[30:0], 1'b0}
                              : {w_diff[31:0],  r_acc[30:0], 1'b1};

  // With a zero divisor every step passes the dividend bit straight into the
  // remainder, so after 32 steps the remainder is the dividend magnitude and
  // the sign-fixed remainder equals the original foutput1.
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;
  assign w_prod = (~r_op[0] & (r_sa ^ r_sb)) ? neg64(r_acc) : r_acc;
  assign w_quo  = (r_m == 32'd0) ? DIV0_LO
                : ((r_sa ^ r_sb) ? neg32(r_acc[31:0]) : r_acc[31:0]);
  assign w_rem  = r_sa ? neg32(r_acc[63:32]) : r_acc[63:32];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_launch) w_next = S_RUN;
      S_RUN: begin
        if (bus.flush)            w_next = S_IDLE;
        else if (r_cnt == 5'd31)  w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_FIX) & ~bus.flush;
      if (r_state == S_RUN && !bus.flush) r_cnt <= r_cnt + 5'd1;
      else                                r_cnt <= 5'd0;
      if (r_state == S_FIX && !bus.flush) begin
        if (r_op[1]) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
      end else if (r_state == S_IDLE && !w_launch) begin
        if (bus.mthi) r_hi <= bus.foutput1;
        if (bus.mtlo) r_lo <= bus.foutput1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_op  <= bus.op;
      r_sa  <= w_sa;
      r_sb  <= w_sb;
      r_m   <= bus.op[1] ? w_bmag : w_amag;
      r_acc <= {32'd0, bus.op[1] ? w_amag : w_bmag};
    end else if (r_state == S_RUN) begin
      r_acc <= r_op[1] ? w_dstep : w_mstep;
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;

endmodule
